lsu_word_bridge: RTL
====================

# lsu_word_bridge

Load/store bridge between the execute stage and the word-addressed data memory. It accepts byte-addressed load/store requests of byte, halfword or word size and drives the memory's `addr`/`read`/`write`/`mem_in` port. It returns aligned, extended load data, and performs read-modify-write for sub-word stores. Misaligned and out-of-range requests are rejected with an error response and no memory access.

## Interface
Parameters:
- `MEM_WORDS`, default `2**MemAddrWidth`: number of 32-bit words in data memory; a word index at or above this value is out of range.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = reserved (error).
- `req_signed` in 1: sign-extend sub-word loads.
- `req_addr` in `Register`: byte address.
- `req_wdata` in `Register`: store data, taken from the low bits for sub-word stores.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out `Register`: load result; 0 for stores and errors.
- `resp_err` out 1: qualified by `resp_valid`.
- `mem_addr` out `Register`: word index, equal to `{2'b00, addr[31:2]}`.
- `mem_read` out `Signal`: drives DataMemory `read`.
- `mem_write` out `Signal`: drives DataMemory `write`.
- `mem_wdata` out `Register`: drives DataMemory `mem_in`.
- `mem_rdata` in `Register`: from DataMemory `mem_out`; valid only while `mem_read` = `ENABLE`.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` with `req_ready` high, latch `req_*` and classify the request:
    - error → DONE with `err` = 1;
    - load → RD;
    - word store → WR;
    - byte or half store → RD.
- **RD**
  - `mem_read` = `ENABLE`.
  - At the clock edge, capture `mem_rdata` into the word buffer.
  - Load → DONE; sub-word store → WR.
- **WR**
  - `mem_write` = `ENABLE`.
  - `mem_wdata` = merged word. For a word store this is `req_wdata`; otherwise it is the buffered word with the target lane replaced.
  - → DONE.
- **DONE**
  - `resp_valid` = 1 for exactly one cycle.
  - `resp_rdata` and `resp_err` are driven from registers.
  - → IDLE.
- There is no response backpressure; the consumer must take the response in the DONE cycle.
- Lanes are little-endian:
  - byte k occupies bits `[8k+7:8k]`, with k = `addr[1:0]`;
  - the halfword occupies bits `[16h+15:16h]`, with h = `addr[1]`.
- Load result: the selected lane is shifted to bit 0 and extended to 32 bits (see Configuration). A word load returns the word unmodified.
- Error conditions, with no memory access (both `mem_read` and `mem_write` stay `DISABLE`):
  - `req_size` = 3;
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0;
  - `addr[31:2]` ≥ `MEM_WORDS`.
- Outside RD and WR, `mem_read` and `mem_write` = `DISABLE`.
- `mem_addr` and `mem_wdata` hold their last values between accesses.

## Timing
- Reset values (asynchronous):
  - state IDLE;
  - `resp_valid` 0, `resp_err` 0, `resp_rdata` 0;
  - `mem_read` and `mem_write` `DISABLE`;
  - `mem_addr` 0, `mem_wdata` 0;
  - `req_ready` forced to 0 while `rst_n` is low.
- Latency from the accept edge T0 to the `resp_valid` cycle:
  - load: RD in cycle 1, DONE in cycle 2;
  - word store: WR in cycle 1, DONE in cycle 2;
  - sub-word store: RD in cycle 1, WR in cycle 2, DONE in cycle 3;
  - error: DONE in cycle 1.
- The next request can be accepted in the cycle after DONE.
- The memory write commits on the edge that ends the WR cycle.
- Reset asserted in RD or WR: the operation is abandoned, `mem_write` drops immediately, and no write commits and no response is issued.
- `req_*` inputs are ignored outside IDLE; the latched copies are used throughout the operation.

## Configuration
- `LSU_SIGNED_LOAD_EN` defined: byte and half loads with `req_signed` = 1 sign-extend from bit 7 or bit 15; with `req_signed` = 0 they zero-extend.
- `LSU_SIGNED_LOAD_EN` undefined: `req_signed` is ignored and all sub-word loads zero-extend.

## Test plan
- Memory word 4 = `0x8844_22F1`; load byte at addr `0x13`, signed:
  - with the macro defined → `resp_rdata` = `0xFFFF_FF88`, 2 cycles after accept;
  - with the macro undefined → `0x0000_0088`.
- Word 4 = `0x8844_22F1`; store half `0xABCD` to addr `0x10` → RD, then WR with `mem_wdata` = `0x8844_ABCD`; `resp_valid` 3 cycles after accept; a subsequent word load from addr `0x10` returns `0x8844_ABCD`.
- Store word `0xDEAD_BEEF` to addr `0x20` → single WR cycle with `mem_addr` = 8; `resp_err` = 0.
- Misaligned requests: half at addr `0x11`, word at addr `0x12`, and `req_size` = 3 → each gives `resp_err` = 1 one cycle after accept, with `mem_read` and `mem_write` `DISABLE` throughout.
- Address `MEM_WORDS*4` → `resp_err` = 1.
- Assert `rst_n` low during the WR cycle of a byte store → target word unchanged, `resp_valid` never asserted, `req_ready` = 1 on the first cycle after release.

Source files
------------

// File: rtl/lsu_word_bridge.sv
// lsu_word_bridge: load/store bridge between the execute stage and a
// word-addressed data memory. Accepts byte/half/word requests at byte
// addresses, performs read-modify-write for sub-word stores, and returns
// lane-aligned, extended load data. Misaligned or out-of-range requests
// are answered with resp_err and never touch memory.
//
// Optional feature macro: LSU_SIGNED_LOAD_EN
//   defined   -> req_signed selects sign extension of byte/half loads
//   undefined -> req_signed is ignored; sub-word loads zero-extend
module lsu_word_bridge #(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned MEM_WORDS      = 2**MEM_ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic       ENABLE    = 1'b1;
    localparam logic       DISABLE   = 1'b0;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    state_t      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        sign_ext;
    logic        req_err;
    logic        accept;
    logic [31:0] word_idx;

`ifdef LSU_SIGNED_LOAD_EN
    logic        signed_q;
    assign sign_ext = signed_q;
`else
    logic        unused_req_signed;
    assign unused_req_signed = req_signed;
    assign sign_ext = 1'b0;
`endif

    // Shift the addressed lane down to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: res = {{24{sx & b[7]}}, b};
            SIZE_HALF: res = {{16{sx & h[15]}}, h};
            default:   res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of the buffered word with the store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (size)
            SIZE_BYTE: res[{lane, 3'b000} +: 8] = data[7:0];
            SIZE_HALF: begin
                if (lane[1]) res[31:16] = data[15:0];
                else         res[15:0]  = data[15:0];
            end
            default:   res = data;
        endcase
        return res;
    endfunction

    assign word_idx = {2'b00, req_addr[31:2]};
    assign accept   = req_valid & req_ready;

    // Classify the incoming request: size/alignment legality and range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        req_err = 1'b0;
        case (req_size)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = req_addr[0];
            SIZE_WORD: req_err = |req_addr[1:0];
            default:   req_err = 1'b1;
        endcase
        if (word_idx >= 32'(MEM_WORDS)) req_err = 1'b1;
    end

    // Next-state logic and state-decoded handshake/memory strobes.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = DISABLE;
        mem_write  = DISABLE;
        case (state_q)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    if (req_err)                     state_d = DONE;
                    else if (!req_write)             state_d = RD;
                    else if (req_size == SIZE_WORD)  state_d = WR;
                    else                             state_d = RD;
                end
            end
            RD: begin
                mem_read = ENABLE;
                state_d  = write_q ? WR : DONE;
            end
            WR: begin
                mem_write = ENABLE;
                state_d   = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; asynchronous reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request latch, memory address/data registers and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            size_q     <= SIZE_BYTE;
            lane_q     <= 2'd0;
            wdata_q    <= '0;
`ifdef LSU_SIGNED_LOAD_EN
            signed_q   <= 1'b0;
`endif
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
`ifdef LSU_SIGNED_LOAD_EN
                        signed_q   <= req_signed;
`endif
                        resp_rdata <= '0;
                        resp_err   <= req_err;
                        // Rejected requests leave the memory port untouched.
                        if (!req_err) begin
                            mem_addr <= word_idx;
                            if (req_write && req_size == SIZE_WORD)
                                mem_wdata <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (write_q)
                        mem_wdata  <= merge_lane(mem_rdata, wdata_q, size_q, lane_q);
                    else
                        resp_rdata <= load_extend(mem_rdata, size_q, lane_q, sign_ext);
                end
                default: ;
            endcase
        end
    end

endmodule
